module_disp_arbiter: RTL and testbench
======================================

// Module: module_disp_arbiter
// PURPOSE
//   Round-robin scheduler that shares the 4-digit display controller between
//   NUM_REQ result sources (operand entry, ALU result, status codes).
//   - Grants one requester at a time.
//   - Clamps the granted value to MAX_VALUE.
//   - Issues a one-cycle result_valid pulse and follows the controller's busy
//     handshake to completion.
//   - Enforces a minimum on-screen hold time before the next grant.
//   Sits between the requesters and module_disp_controller.
// PARAMETERS
//   NUM_REQ       3     number of requesters (>=2)
//   RESULT_WIDTH  14    value width, matches module_disp_controller
//   MAX_VALUE     9999  clamp ceiling for displayed values
//   BUSY_TIMEOUT  2000  max cycles from the valid pulse to busy falling
//   HOLD_CYCLES   64    minimum cycles a value is displayed before the next grant (0 allowed)
// PORTS
//   clk           in   1                     system clock
//   rst_n         in   1                     synchronous reset, active-low
//   req_i         in   NUM_REQ               request; held high until ack_o
//   value_i       in   NUM_REQ*RESULT_WIDTH  requester k value at [k*RESULT_WIDTH +: RESULT_WIDTH]
//   ack_o         out  NUM_REQ               one-cycle completion pulse to granted requester
//   result_in     out  RESULT_WIDTH          value to display controller; stable between grants
//   result_valid  out  1                     one-cycle start pulse to display controller
//   disp_busy     in   1                     busy from display controller
//   grant_idx     out  $clog2(NUM_REQ)       index of current/last granted requester
//   arb_busy      out  1                     high in every state except IDLE
//   clamped_o     out  1                     high while the displayed value was clamped
//   timeout_err   out  1                     sticky; disp_busy handshake timed out
// BEHAVIOUR
//   Reset (rst_n low at posedge)
//     - state=IDLE; all outputs 0; round-robin pointer=0 (req 0 highest priority).
//     - Mid-operation reset abandons the transaction: no ack is issued.
//   Registers
//     - All outputs are registered.
//     - The round-robin pointer is part of arbiter state.
//   FSM: IDLE -> ISSUE -> WAIT_BUSY -> WAIT_DONE -> HOLD -> IDLE
//     IDLE
//       - If any req_i is high, grant the first high bit searching from the
//         pointer upward with wrap-around.
//       - Latch value v = min(value_i[k], MAX_VALUE) into result_in.
//       - clamped_o <= (value_i[k] > MAX_VALUE); grant_idx <= k;
//         pointer <= (k+1) mod NUM_REQ.
//       - Next state: ISSUE.
//     ISSUE
//       - result_valid=1 for exactly this cycle.
//       - Clear the timeout counter; next state: WAIT_BUSY.
//       - Latency: req sampled at edge t -> result_valid high in cycle t+1.
//     WAIT_BUSY
//       - disp_busy=1 -> WAIT_DONE.
//     WAIT_DONE
//       - disp_busy=0 -> HOLD, with ack_o[grant_idx]=1 for one cycle.
//     Timeout (WAIT_BUSY and WAIT_DONE)
//       - One counter spans both states.
//       - When it reaches BUSY_TIMEOUT: timeout_err<=1 (sticky until reset),
//         pulse ack_o[grant_idx], go to HOLD.
//       - If the busy event and timeout occur in the same cycle, the busy
//         event wins; no error.
//     HOLD
//       - Count HOLD_CYCLES, then IDLE.
//       - With HOLD_CYCLES=0, go straight to IDLE.
//       - req_i is ignored in HOLD.
//   Requester rules
//     - req_i and value_i are sampled only in IDLE.
//     - value_i changes after grant are ignored.
//     - A req dropped before grant is lost with no ack.
//     - The requester deasserts req the cycle after seeing ack.
//   Fairness
//     - A requester that keeps req high waits at most NUM_REQ-1 transactions.
//   Boundaries
//     - value 0 and value MAX_VALUE pass unclamped.
//     - MAX_VALUE+1 through 2^RESULT_WIDTH-1 are clamped.
//   result_in holds its last value after completion, so the display persists.
// TESTING
//   1 Reset, req_i=001, value0=12
//     -> result_valid pulse 1 cycle after req sample; result_in=12;
//        ack_o=001 after busy falls; no second grant before HOLD_CYCLES elapse.
//   2 value1=16383 on req_i=010
//     -> result_in=9999, clamped_o=1; next grant with value 9999 -> clamped_o=0.
//   3 req_i=111 held, each requester drops req after its ack
//     -> grant order 0,1,2; re-raise all three -> order 0,1,2 again
//        (pointer wrapped).
//   4 disp_busy tied 0 after grant
//     -> timeout_err=1 after BUSY_TIMEOUT cycles, ack still pulsed,
//        FSM returns to IDLE and serves the next request.
//   5 rst_n low for 1 cycle during WAIT_DONE
//     -> all outputs 0, no ack; pending req serviced afresh from requester 0.
//   6 HOLD_CYCLES=0 build with back-to-back requests
//     -> next result_valid exactly 2 cycles after the previous ack;
//        segs/an on the real controller show each value (0000, 0012, 3057).

Source files
------------

// File: rtl/module_disp_arbiter.sv
// Round-robin arbiter sharing the 4-digit display controller between NUM_REQ sources.
// Grants one requester, clamps its value, drives the busy handshake and enforces a hold time.
module module_disp_arbiter #(
    parameter int unsigned NUM_REQ      = 3,
    parameter int unsigned RESULT_WIDTH = 14,
    parameter int unsigned MAX_VALUE    = 9999,
    parameter int unsigned BUSY_TIMEOUT = 2000,
    parameter int unsigned HOLD_CYCLES  = 64
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_i,
    input  logic [NUM_REQ*RESULT_WIDTH-1:0] value_i,
    output logic [NUM_REQ-1:0]              ack_o,
    output logic [RESULT_WIDTH-1:0]         result_in,
    output logic                            result_valid,
    input  logic                            disp_busy,
    output logic [$clog2(NUM_REQ)-1:0]      grant_idx,
    output logic                            arb_busy,
    output logic                            clamped_o,
    output logic                            timeout_err
);

    localparam int unsigned IW = $clog2(NUM_REQ);
    localparam int unsigned TW = $clog2(BUSY_TIMEOUT + 1);
    localparam int unsigned HW = $clog2(HOLD_CYCLES + 2);
    localparam logic [RESULT_WIDTH-1:0] MAX_V     = RESULT_WIDTH'(MAX_VALUE);
    localparam logic [TW-1:0]           TO_LAST   = TW'(BUSY_TIMEOUT - 1);
    localparam logic [HW-1:0]           HOLD_LAST = HW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        HOLD
    } state_t;

    state_t                  state, state_nxt;
    logic [IW-1:0]           ptr;
    logic [IW-1:0]           pick;
    logic                    pick_vld;
    logic [RESULT_WIDTH-1:0] pick_raw;
    logic [TW-1:0]           to_cnt;
    logic [HW-1:0]           hold_cnt;
    logic                    done_evt;
    logic                    to_evt;
    logic                    grant;

    // First active request at or after the pointer, wrapping around.
    always_comb begin
        logic [IW:0] j;
        pick     = '0;
        pick_vld = 1'b0;
        j        = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            j = {1'b0, ptr} + (IW+1)'(i);
            if (j >= (IW+1)'(NUM_REQ))
                j = j - (IW+1)'(NUM_REQ);
            if (!pick_vld && req_i[j[IW-1:0]]) begin
                pick     = j[IW-1:0];
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        pick_raw = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick == IW'(i))
                pick_raw = value_i[i*RESULT_WIDTH +: RESULT_WIDTH];
        end
    end

    assign grant = (state == IDLE) && pick_vld;

    // A busy edge in the same cycle as the timeout takes priority over the timeout.
    always_comb begin
        state_nxt = state;
        done_evt  = 1'b0;
        to_evt    = 1'b0;
        case (state)
            IDLE:      if (pick_vld) state_nxt = ISSUE;
            ISSUE:     state_nxt = WAIT_BUSY;
            WAIT_BUSY: begin
                if (disp_busy) begin
                    state_nxt = WAIT_DONE;
                end else if (to_cnt == TO_LAST) begin
                    to_evt    = 1'b1;
                    state_nxt = HOLD;
                end
            end
            WAIT_DONE: begin
                if (!disp_busy) begin
                    done_evt  = 1'b1;
                    state_nxt = HOLD;
                end else if (to_cnt == TO_LAST) begin
                    to_evt    = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD:      if (hold_cnt == HOLD_LAST) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr          <= '0;
            result_in    <= '0;
            result_valid <= 1'b0;
            ack_o        <= '0;
            grant_idx    <= '0;
            arb_busy     <= 1'b0;
            clamped_o    <= 1'b0;
            timeout_err  <= 1'b0;
            to_cnt       <= '0;
            hold_cnt     <= '0;
        end else begin
            result_valid <= grant;
            arb_busy     <= (state_nxt != IDLE);
            ack_o        <= '0;
            if (grant) begin
                result_in <= (pick_raw > MAX_V) ? MAX_V : pick_raw;
                clamped_o <= (pick_raw > MAX_V);
                grant_idx <= pick;
                ptr       <= (pick == IW'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
            end
            if (state == ISSUE)
                to_cnt <= '0;
            else if (state == WAIT_BUSY || state == WAIT_DONE)
                to_cnt <= to_cnt + 1'b1;
            if (state != HOLD)
                hold_cnt <= '0;
            else
                hold_cnt <= hold_cnt + 1'b1;
            if (done_evt || to_evt)
                ack_o[grant_idx] <= 1'b1;
            if (to_evt)
                timeout_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_module_disp_arbiter.sv
// Scoreboard bench for module_disp_arbiter: a HOLD_CYCLES=8 instance and a HOLD_CYCLES=0 instance,
// with a small display-controller busy model answering each result_valid pulse.
module tb_module_disp_arbiter;

    localparam int RW = 14;
    localparam int NR = 3;

    typedef struct {
        int d; int idx; int v; int c; int lat; int gap; int t;
    } g_t;
    typedef struct {
        int d; int idx; int v; int te; int alat;
    } a_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          rst_q = 1'b1;
    int            cyc = 0;
    logic [NR-1:0]    req   [2];
    logic [NR*RW-1:0] val   [2];
    logic [NR-1:0]    ack   [2];
    logic [RW-1:0]    ri    [2];
    logic             rv    [2];
    logic             dbusy [2];
    logic [1:0]       gi    [2];
    logic             ab    [2];
    logic             co    [2];
    logic             te    [2];

    int  dcnt [2];
    int  bl = 4;
    bit  busy_dead [2];
    g_t  gq [$];
    a_t  aq [$];
    int  checks = 0;
    int  failures = 0;
    int  last_ack   [2];
    int  last_valid [2];

    module_disp_arbiter #(
        .NUM_REQ(3), .RESULT_WIDTH(14), .MAX_VALUE(9999), .BUSY_TIMEOUT(20), .HOLD_CYCLES(8)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req_i(req[0]), .value_i(val[0]), .ack_o(ack[0]),
        .result_in(ri[0]), .result_valid(rv[0]), .disp_busy(dbusy[0]), .grant_idx(gi[0]),
        .arb_busy(ab[0]), .clamped_o(co[0]), .timeout_err(te[0])
    );

    module_disp_arbiter #(
        .NUM_REQ(3), .RESULT_WIDTH(14), .MAX_VALUE(9999), .BUSY_TIMEOUT(20), .HOLD_CYCLES(0)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_i(req[1]), .value_i(val[1]), .ack_o(ack[1]),
        .result_in(ri[1]), .result_valid(rv[1]), .disp_busy(dbusy[1]), .grant_idx(gi[1]),
        .arb_busy(ab[1]), .clamped_o(co[1]), .timeout_err(te[1])
    );

    always @(posedge clk) begin
        rst_q <= rst_n;
        cyc   <= cyc + 1;
    end

    // Display controller stand-in: busy rises the cycle after result_valid and lasts bl cycles.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                dbusy[d] <= 1'b0;
                dcnt[d]  <= 0;
            end else if (rv[d] && !busy_dead[d]) begin
                dbusy[d] <= 1'b1;
                dcnt[d]  <= bl;
            end else if (dcnt[d] != 0) begin
                dcnt[d] <= dcnt[d] - 1;
                if (dcnt[d] == 1)
                    dbusy[d] <= 1'b0;
            end
        end
    end

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++)
            req[d] = req[d] & ~ack[d];
    endtask

    task automatic req_on(input int d, input int k, input int v);
        val[d][k*RW +: RW] = RW'(v);
        req[d][k] = 1'b1;
    endtask

    task automatic exp_g(input int d, input int k, input int v, input int c, input int lat, input int gap);
        gq.push_back('{d, k, v, c, lat, gap, cyc});
    endtask

    task automatic exp_a(input int d, input int k, input int v, input int t, input int alat);
        aq.push_back('{d, k, v, t, alat});
    endtask

    task automatic wait_valid(input int d);
        for (int i = 0; i < 100 && !rv[d]; i++) step();
        chk("wait_valid", int'(rv[d]), 1);
    endtask

    task automatic wait_idle(input int d);
        for (int i = 0; i < 300 && (ab[d] || req[d] != '0); i++) step();
        chk("wait_idle", int'(!ab[d] && req[d] == '0), 1);
    endtask

    // Monitor: compares every valid/ack the DUTs present against the scoreboard queues.
    initial begin
        g_t g;
        a_t a;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (!rst_q)
                    chk("reset_outputs_zero",
                        int'({ri[d], rv[d], ack[d], gi[d], ab[d], co[d], te[d]}), 0);
                if (rv[d]) begin
                    chk("valid_expected", int'(gq.size() != 0), 1);
                    if (gq.size() != 0) begin
                        g = gq.pop_front();
                        chk("valid_dut", d, g.d);
                        chk("grant_idx", int'(gi[d]), g.idx);
                        chk("result_in", int'(ri[d]), g.v);
                        chk("clamped_o", int'(co[d]), g.c);
                        if (g.lat > 0) chk("req_to_valid_latency", cyc - g.t, g.lat);
                        if (g.gap > 0) chk("ack_to_valid_gap", cyc - last_ack[d], g.gap);
                    end
                    last_valid[d] = cyc;
                end
                if (ack[d] != '0) begin
                    chk("ack_expected", int'(aq.size() != 0), 1);
                    if (aq.size() != 0) begin
                        a = aq.pop_front();
                        chk("ack_dut", d, a.d);
                        chk("ack_onehot", int'(ack[d]), 1 << a.idx);
                        chk("result_held", int'(ri[d]), a.v);
                        chk("timeout_err", int'(te[d]), a.te);
                        chk("valid_to_ack", cyc - last_valid[d], a.alat);
                    end
                    last_ack[d] = cyc;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=no_finish required=finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req[d] = '0;
            val[d] = '0;
        end
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Single request; value change after grant must not reach result_in.
        exp_g(0, 0, 12, 0, 1, 0);
        exp_a(0, 0, 12, 0, 6);
        req_on(0, 0, 12);
        wait_valid(0);
        val[0][0 +: RW] = 14'd555;
        for (int i = 0; i < 100 && req[0][0]; i++) step();
        chk("t1_ack_seen", int'(req[0][0]), 0);

        // Raised during HOLD: grant only after the hold time; max input clamps.
        exp_g(0, 1, 9999, 1, 0, 9);
        exp_a(0, 1, 9999, 0, 6);
        req_on(0, 1, 16383);
        wait_idle(0);
        exp_g(0, 2, 9999, 0, 1, 0);
        exp_a(0, 2, 9999, 0, 6);
        req_on(0, 2, 9999);
        wait_idle(0);

        // All three held, two rounds; boundaries 0, MAX, MAX+1.
        exp_g(0, 0, 0, 0, 1, 0);
        exp_g(0, 1, 9999, 0, 0, 9);
        exp_g(0, 2, 9999, 1, 0, 9);
        exp_a(0, 0, 0, 0, 6);
        exp_a(0, 1, 9999, 0, 6);
        exp_a(0, 2, 9999, 0, 6);
        req_on(0, 0, 0);
        req_on(0, 1, 9999);
        req_on(0, 2, 10000);
        wait_idle(0);
        exp_g(0, 0, 7, 0, 1, 0);
        exp_g(0, 1, 8, 0, 0, 9);
        exp_g(0, 2, 9999, 1, 0, 9);
        exp_a(0, 0, 7, 0, 6);
        exp_a(0, 1, 8, 0, 6);
        exp_a(0, 2, 9999, 1 - 1, 6);
        req_on(0, 0, 7);
        req_on(0, 1, 8);
        req_on(0, 2, 10000);
        wait_idle(0);

        // Busy never rises: timeout, ack anyway, error sticks into the next transaction.
        busy_dead[0] = 1'b1;
        exp_g(0, 1, 4095, 0, 1, 0);
        exp_a(0, 1, 4095, 1, 21);
        req_on(0, 1, 4095);
        wait_idle(0);
        busy_dead[0] = 1'b0;
        exp_g(0, 0, 3057, 0, 1, 0);
        exp_a(0, 0, 3057, 1, 6);
        req_on(0, 0, 3057);
        wait_idle(0);

        // Pointer sits at 1; reset during WAIT_DONE abandons req 1 and restarts from req 0.
        bl = 10;
        exp_g(0, 1, 200, 0, 1, 0);
        exp_g(0, 0, 100, 0, 0, 0);
        exp_g(0, 1, 200, 0, 0, 9);
        exp_a(0, 0, 100, 0, 12);
        exp_a(0, 1, 200, 0, 12);
        req_on(0, 0, 100);
        req_on(0, 1, 200);
        wait_valid(0);
        repeat (4) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        wait_idle(0);

        // Zero hold time, back-to-back requests.
        bl = 4;
        exp_g(1, 0, 0, 0, 1, 0);
        exp_g(1, 1, 12, 0, 0, 2);
        exp_g(1, 2, 3057, 0, 0, 2);
        exp_a(1, 0, 0, 0, 6);
        exp_a(1, 1, 12, 0, 6);
        exp_a(1, 2, 3057, 0, 6);
        req_on(1, 0, 0);
        req_on(1, 1, 12);
        req_on(1, 2, 3057);
        wait_idle(1);

        repeat (5) step();
        chk("grant_queue_drained", gq.size(), 0);
        chk("ack_queue_drained", aq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
